// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus: control inputs from ID/CP0, the instruction-memory port,
// and the IF/ID pipeline-register payload.
interface fetch_pc_unit_if;
    logic        EN;
    logic        IntExcReq;
    logic        eret_req;
    logic [31:0] epc_in;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        branch_in_id;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] InstrOut;
    logic [31:0] curPCOut;
    logic [4:0]  ExcCodeOut;
    logic        BDOut;

    // Fetch unit side
    modport master (
        input  EN, IntExcReq, eret_req, epc_in,
        input  redirect_valid, redirect_target, branch_in_id,
        input  imem_rdata,
        output imem_addr, InstrOut, curPCOut, ExcCodeOut, BDOut
    );

    // Pipeline / memory side
    modport slave (
        output EN, IntExcReq, eret_req, epc_in,
        output redirect_valid, redirect_target, branch_in_id,
        output imem_rdata,
        input  imem_addr, InstrOut, curPCOut, ExcCodeOut, BDOut
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: holds the PC, addresses instruction memory and
// hands instruction, PC, fetch exception code and delay-slot flag to IF/ID.
// Next-PC priority: reset > exception entry > ERET > stall > redirect > +4.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IMEM_LO    = 32'h0000_3000,
    parameter logic [31:0] IMEM_HI    = 32'h0000_6FFC
) (
    input  logic           clk,
    input  logic           reset,
    fetch_pc_unit_if.master bus
);

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic        fault;

    // Sequential fetch wraps modulo 2^32; the carry is intentionally dropped.
    assign pc_plus4 = pc_reg + 32'd4;

    // Misaligned or out-of-window fetch raises AdEL; the PC keeps advancing
    // and the exception is taken later when CP0 asserts IntExcReq.
    always_comb begin
        fault = 1'b0;
        if (pc_reg[1:0] != 2'b00)
            fault = 1'b1;
        else if (pc_reg < IMEM_LO || pc_reg > IMEM_HI)
            fault = 1'b1;
    end

    // Next-PC selection; exception entry and ERET override a stall, and
    // both discard any concurrent redirect.
    always_comb begin
        pc_next = pc_plus4;
        if (bus.IntExcReq)
            pc_next = HANDLER_PC;
        else if (bus.eret_req)
            pc_next = bus.epc_in;
        else if (!bus.EN)
            pc_next = pc_reg;
        else if (bus.redirect_valid)
            pc_next = bus.redirect_target;
    end

    // PC register; reset discards anything pending.
    always_ff @(posedge clk) begin
        if (reset)
            pc_reg <= RESET_PC;
        else
            pc_reg <= pc_next;
    end

    // IF/ID payload; a faulting fetch forwards a NOP so nothing executes.
    always_comb begin
        bus.imem_addr  = pc_reg;
        bus.curPCOut   = pc_reg;
        bus.InstrOut   = fault ? 32'd0 : bus.imem_rdata;
        bus.ExcCodeOut = fault ? EXC_ADEL : EXC_NONE;
        bus.BDOut      = bus.branch_in_id;
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: each step pushes the expected PC into a
// scoreboard, and after the clock edge the entry is popped and compared.
module tb_fetch_pc_unit;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    typedef struct {
        string       tag;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];

    fetch_pc_unit_if bus ();

    fetch_pc_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic ref_fault(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc > 32'h0000_6FFC);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle with the current inputs, then compare the popped expectation.
    task automatic step(input string tag, input logic [31:0] exp_pc);
        exp_t e;
        exp_t got_e;
        e.tag = tag;
        e.pc  = exp_pc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            got_e = sb.pop_front();
            check({got_e.tag, ".pc"},   bus.curPCOut, got_e.pc);
            check({got_e.tag, ".addr"}, bus.imem_addr, got_e.pc);
            check({got_e.tag, ".exc"},  {27'd0, bus.ExcCodeOut},
                  ref_fault(got_e.pc) ? 32'd4 : 32'd0);
            check({got_e.tag, ".instr"}, bus.InstrOut,
                  ref_fault(got_e.pc) ? 32'd0 : bus.imem_rdata);
            $display("step %-12s pc=%h exc=%0d instr=%h bd=%b",
                     got_e.tag, bus.curPCOut, bus.ExcCodeOut, bus.InstrOut, bus.BDOut);
        end
    endtask

    task automatic go_to(input logic [31:0] target);
        bus.EN = 1'b1;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = target;
        step("goto", target);
        bus.redirect_valid  = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        clk    = 1'b0;
        reset  = 1'b1;
        bus.EN = 1'b0;
        bus.IntExcReq = 1'b0;
        bus.eret_req  = 1'b0;
        bus.epc_in    = 32'd0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'd0;
        bus.branch_in_id    = 1'b0;
        bus.imem_rdata      = 32'h2408_0001;

        // Reset and sequential fetch
        #2;
        step("reset", 32'h0000_3000);
        reset  = 1'b0;
        bus.EN = 1'b1;
        step("seq1", 32'h0000_3004);
        step("seq2", 32'h0000_3008);
        step("seq3", 32'h0000_300C);
        step("seq4", 32'h0000_3010);

        // Branch in ID with redirect: delay slot still fetched, BD flagged
        bus.branch_in_id    = 1'b1;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h0000_3100;
        #1;
        check("bd_flag", {31'd0, bus.BDOut}, 32'd1);
        check("bd_pc", bus.curPCOut, 32'h0000_3010);
        step("branch", 32'h0000_3100);
        bus.branch_in_id   = 1'b0;
        bus.redirect_valid = 1'b0;
        #1;
        check("bd_clear", {31'd0, bus.BDOut}, 32'd0);

        // Stall holds PC; InstrOut tracks imem during stall
        go_to(32'h0000_3020);
        bus.EN = 1'b0;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h0000_3300;
        step("stall1", 32'h0000_3020);
        bus.imem_rdata = 32'h1234_5678;
        #1;
        check("stall_instr", bus.InstrOut, 32'h1234_5678);
        step("stall2", 32'h0000_3020);
        bus.redirect_valid = 1'b0;
        bus.EN = 1'b1;
        step("resume", 32'h0000_3024);

        // Misaligned target faults; exception entry overrides stall
        go_to(32'h0000_3002);
        bus.EN = 1'b0;
        bus.IntExcReq = 1'b1;
        step("exc_stall", 32'h0000_4180);
        bus.IntExcReq = 1'b0;

        // ERET beats redirect; exception beats ERET
        bus.EN = 1'b1;
        bus.eret_req = 1'b1;
        bus.epc_in   = 32'h0000_3044;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h0000_3200;
        step("eret", 32'h0000_3044);
        bus.IntExcReq = 1'b1;
        step("exc_eret", 32'h0000_4180);
        bus.IntExcReq = 1'b0;
        bus.EN = 1'b0;
        bus.epc_in = 32'h0000_3048;
        step("eret_stall", 32'h0000_3048);
        bus.eret_req = 1'b0;
        bus.redirect_valid = 1'b0;

        // Reset during a stall
        go_to(32'h0000_3500);
        bus.EN = 1'b0;
        step("hold3500", 32'h0000_3500);
        reset = 1'b1;
        bus.IntExcReq = 1'b1;
        step("reset_stall", 32'h0000_3000);
        reset = 1'b0;
        bus.IntExcReq = 1'b0;

        // Window boundaries
        go_to(32'h0000_6FFC);
        bus.EN = 1'b1;
        step("above_hi", 32'h0000_7000);
        go_to(32'h0000_2FFC);

        // Wrap-around
        go_to(32'hFFFF_FFFC);
        bus.EN = 1'b1;
        step("wrap", 32'h0000_0000);
        check("wrap_exc", {27'd0, bus.ExcCodeOut}, 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch stage of the pipelined MIPS core. Holds the program counter, drives the instruction-memory address, and produces the instruction word, fetch PC, fetch exception code and branch-delay flag for the IF/ID pipeline register. It applies stall, branch/jump redirect, exception entry and ERET return with a fixed priority.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- HANDLER_PC, 32'h0000_4180, exception/interrupt entry address.
- IMEM_LO, 32'h0000_3000, lowest legal fetch address (inclusive).
- IMEM_HI, 32'h0000_6FFC, highest legal fetch address (inclusive).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- EN  in  1  1 = pipeline advances; 0 = IF/ID stalled, PC holds.
- IntExcReq  in  1  exception/interrupt taken this cycle (from CP0).
- eret_req  in  1  ERET committing this cycle.
- epc_in  in  32  return address from CP0, sampled when eret_req=1.
- redirect_valid  in  1  branch taken / jump resolved in ID.
- redirect_target  in  32  target address for redirect_valid.
- branch_in_id  in  1  instruction currently in ID is a branch or jump.
- imem_addr  out  32  instruction-memory address, equal to PC.
- imem_rdata  in  32  instruction word at imem_addr, combinational.
- InstrOut  out  32  instruction to IF/ID.
- curPCOut  out  32  PC of InstrOut.
- ExcCodeOut  out  5  0 = none, 4 = AdEL on fetch.
- BDOut  out  1  fetched instruction sits in a branch delay slot.

## Operation
- State: one 32-bit register pc. No other architectural state.
- Fault detection, combinational on pc: fault = (pc[1:0] != 0) or pc < IMEM_LO or pc > IMEM_HI.
- Outputs, combinational:
  - imem_addr = pc; curPCOut = pc.
  - InstrOut = fault ? 0 : imem_rdata.
  - ExcCodeOut = fault ? 5'd4 : 5'd0.
  - BDOut = branch_in_id.
- Next-pc priority, highest first, evaluated each rising edge:
  1. reset -> RESET_PC.
  2. IntExcReq -> HANDLER_PC, regardless of EN.
  3. eret_req -> epc_in, regardless of EN.
  4. EN=0 -> hold pc.
  5. redirect_valid -> redirect_target.
  6. otherwise -> pc + 4.
- Arithmetic: pc + 4 is a 32-bit add that wraps modulo 2^32. No carry out.
- The delay slot is fetched in the same cycle that ID presents the redirect, so the redirect never suppresses the current fetch.
- A faulting PC still advances normally (pc + 4 or redirect). The fault travels down the pipe through ExcCodeOut. The resulting IntExcReq is what redirects fetch.
- redirect_target and epc_in are not range-checked at load time. A bad target faults when it is fetched.

## Timing
- Reset: pc = 32'h0000_3000 on the first edge with reset=1.
  - Following outputs: curPCOut = imem_addr = 0x3000, ExcCodeOut = 0, InstrOut = imem_rdata. BDOut follows branch_in_id.
- Latency: a redirect, exception or ERET presented in cycle N makes curPCOut show the new address in cycle N+1. Sequential fetch also has a latency of one cycle.
- Stall: while EN=0 with no IntExcReq or eret_req, all outputs are stable except InstrOut/BDOut, which track their combinational sources.
- IntExcReq together with eret_req: IntExcReq wins.
- IntExcReq or eret_req together with redirect_valid: the redirect is discarded.
- reset together with anything: reset wins.
- Reset mid-stall or mid-redirect: pc = RESET_PC. Nothing pending is remembered.
- Wrap: pc = 0xFFFF_FFFC with EN=1 and no redirect gives next pc = 0x0000_0000, which faults with AdEL.

## Test plan
- Reset then EN=1 for 3 cycles, imem returns 0x2408_0001 -> curPCOut 0x3000, 0x3004, 0x3008; ExcCodeOut 0; InstrOut 0x2408_0001.
- At pc 0x3010, branch_in_id=1 and redirect_valid=1, target 0x3100 -> BDOut=1 while curPCOut=0x3010; next cycle curPCOut=0x3100.
- EN=0 for 2 cycles at pc 0x3020, then EN=1 -> curPCOut holds 0x3020 for both stall cycles, then 0x3024.
- redirect_target 0x3002 -> next cycle ExcCodeOut=4, InstrOut=0, curPCOut=0x3002. Then IntExcReq=1 with EN=0 -> next curPCOut=0x4180.
- eret_req=1 with epc_in=0x3044, IntExcReq=0, redirect_valid=1 (target 0x3200) -> next curPCOut=0x3044. Repeating with IntExcReq=1 as well -> 0x4180.
- Assert reset during a stall at pc 0x3500 -> next curPCOut=0x3000. With pc forced to 0xFFFF_FFFC and EN=1 -> next pc 0x0000_0000, ExcCodeOut=4.
